// File: rtl/paired_sat_counter.sv
// Multi-channel saturating index/sum counter pair with clear, completion and overrun tracking.
// Define PAIRED_SAT_COUNTER_ASSERT_EN to compile in invariant and parameter-range assertions.
module paired_sat_counter #(
  parameter int unsigned CH    = 4,
  parameter int unsigned W     = 10,
  parameter int unsigned START = 1,
  parameter int unsigned LIMIT = 250
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH-1:0]              sel,
  input  logic [CH-1:0]              clr,
  output logic [CH*W-1:0]            i,
  output logic [CH*W-1:0]            sn,
  output logic [CH-1:0]              done,
  output logic                       all_done,
  output logic [$clog2(CH+1)-1:0]    done_cnt,
  output logic [CH-1:0]              overrun
);

  localparam int unsigned CW = $clog2(CH + 1);
  localparam logic [W-1:0] I_START = W'(START);
  localparam logic [W-1:0] I_LIMIT = W'(LIMIT);
  localparam logic [W-1:0] I_FINAL = W'(LIMIT + 1);
  localparam logic [W-1:0] I_SPAN  = W'(LIMIT - START + 1);
  localparam logic [W-1:0] ONE     = W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    state_t       st_q, st_d;
    logic [W-1:0] i_q, i_d;
    logic [W-1:0] sn_q, sn_d;
    logic         ov_q, ov_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q <= S_IDLE;
        i_q  <= I_START;
        sn_q <= '0;
        ov_q <= 1'b0;
      end else begin
        st_q <= st_d;
        i_q  <= i_d;
        sn_q <= sn_d;
        ov_q <= ov_d;
      end
    end

    // Clear outranks enable, so a clear on the final increment leaves the channel idle.
    always_comb begin
      st_d = st_q;
      i_d  = i_q;
      sn_d = sn_q;
      ov_d = ov_q;
      if (clr[k]) begin
        st_d = S_IDLE;
        i_d  = I_START;
        sn_d = '0;
        ov_d = 1'b0;
      end else if (sel[k]) begin
        if (st_q != S_DONE) begin
          i_d  = i_q + ONE;
          sn_d = sn_q + ONE;
          st_d = (i_q == I_LIMIT) ? S_DONE : S_RUN;
        end else begin
          ov_d = 1'b1;
        end
      end
    end

    assign i[k*W +: W]  = i_q;
    assign sn[k*W +: W] = sn_q;
    assign done[k]      = (st_q == S_DONE);
    assign overrun[k]   = ov_q;

`ifdef PAIRED_SAT_COUNTER_ASSERT_EN
    a_sum_tracks_index: assert property (@(posedge clk) disable iff (!rst_n)
      sn_q == i_q - I_START);
    a_index_range: assert property (@(posedge clk) disable iff (!rst_n)
      (i_q >= I_START) && (i_q <= I_FINAL));
    a_done_matches: assert property (@(posedge clk) disable iff (!rst_n)
      (st_q == S_DONE) == (i_q == I_FINAL));
    a_final_sum: assert property (@(posedge clk) disable iff (!rst_n)
      !((i_q > I_LIMIT) && (sn_q != I_SPAN) && (sn_q != '0)));
`endif
  end

  assign all_done = &done;

  always_comb begin
    done_cnt = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      done_cnt = done_cnt + CW'(done[k]);
    end
  end

`ifdef PAIRED_SAT_COUNTER_ASSERT_EN
  if (CH < 1 || CH > 16) begin : g_bad_ch
    $error("paired_sat_counter: CH must be in 1..16");
  end
  if (START > LIMIT) begin : g_bad_start
    $error("paired_sat_counter: START must not exceed LIMIT");
  end
  if ((LIMIT + 1) >= (2 ** W)) begin : g_bad_width
    $error("paired_sat_counter: LIMIT+1 must fit in W bits");
  end
`endif

endmodule

// File: tb/tb_paired_sat_counter.sv
// Directed bench for paired_sat_counter: per-cycle compare against a count-based model plus literal checkpoints.
module tb_paired_sat_counter;

  localparam int CH    = 4;
  localparam int W     = 10;
  localparam int START = 1;
  localparam int LIMIT = 250;
  localparam int SPAN  = LIMIT - START + 1;
  localparam int CW    = $clog2(CH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     sel = '0;
  logic [CH-1:0]     clr = '0;
  logic [CH*W-1:0]   i_w;
  logic [CH*W-1:0]   sn_w;
  logic [CH-1:0]     done_w;
  logic              all_done_w;
  logic [CW-1:0]     done_cnt_w;
  logic [CH-1:0]     overrun_w;

  int  nvec = 0;
  int  nerr = 0;
  bit  check_en = 1'b0;

  // Model: each channel is just "how many increments taken" plus a sticky overrun bit.
  int  cnt [CH];
  bit  ov  [CH];

  paired_sat_counter #(.CH(CH), .W(W), .START(START), .LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .clr      (clr),
    .i        (i_w),
    .sn       (sn_w),
    .done     (done_w),
    .all_done (all_done_w),
    .done_cnt (done_cnt_w),
    .overrun  (overrun_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        cnt[k] = 0;
        ov[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (clr[k]) begin
          cnt[k] = 0;
          ov[k]  = 1'b0;
        end else if (sel[k]) begin
          if (cnt[k] < SPAN) cnt[k] = cnt[k] + 1;
          else ov[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s ch%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic int fi(input int k);
    return int'(i_w[k*W +: W]);
  endfunction

  function automatic int fs(input int k);
    return int'(sn_w[k*W +: W]);
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      int nd;
      nd = 0;
      for (int k = 0; k < CH; k++) begin
        chk("i", k, fi(k), START + cnt[k]);
        chk("sn", k, fs(k), cnt[k]);
        chk("done", k, done_w[k], (cnt[k] == SPAN) ? 1 : 0);
        chk("overrun", k, overrun_w[k], ov[k] ? 1 : 0);
        if (cnt[k] == SPAN) nd++;
      end
      chk("all_done", 0, all_done_w, (nd == CH) ? 1 : 0);
      chk("done_cnt", 0, done_cnt_w, nd);
    end
  end

  task automatic cyc(input logic [CH-1:0] s, input logic [CH-1:0] c);
    sel = s;
    clr = c;
    @(negedge clk);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      chk("rst_i", k, fi(k), 1);
      chk("rst_sn", k, fs(k), 0);
    end
    chk("rst_done", 0, done_w, 0);
    chk("rst_done_cnt", 0, done_cnt_w, 0);

    for (int t = 0; t < 249; t++) cyc(4'b0001, 4'b0000);
    chk("ch0_before_last_done", 0, done_w[0], 0);
    cyc(4'b0001, 4'b0000);
    chk("ch0_i_final", 0, fi(0), 251);
    chk("ch0_sn_final", 0, fs(0), 250);
    chk("done_vec", 0, done_w, 4'b0001);
    chk("done_cnt_one", 0, done_cnt_w, 1);
    chk("ch3_idle_i", 3, fi(3), 1);
    chk("ch3_idle_sn", 3, fs(3), 0);

    for (int t = 0; t < 3; t++) cyc(4'b0001, 4'b0000);
    chk("ch0_hold_i", 0, fi(0), 251);
    chk("ch0_hold_sn", 0, fs(0), 250);
    chk("ch0_overrun", 0, overrun_w, 4'b0001);
    cyc(4'b0000, 4'b0001);
    chk("ch0_clr_i", 0, fi(0), 1);
    chk("ch0_clr_sn", 0, fs(0), 0);
    chk("ch0_clr_done", 0, done_w[0], 0);
    chk("ch0_clr_overrun", 0, overrun_w[0], 0);

    for (int t = 0; t < 100; t++) cyc((t % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000);
    chk("ch2_toggle_i", 2, fi(2), 51);
    chk("ch2_toggle_sn", 2, fs(2), 50);
    chk("ch2_toggle_done", 2, done_w[2], 0);

    for (int t = 0; t < 249; t++) cyc(4'b0010, 4'b0000);
    chk("ch1_at_limit_i", 1, fi(1), 250);
    cyc(4'b0010, 4'b0010);
    chk("ch1_clr_wins_i", 1, fi(1), 1);
    chk("ch1_clr_wins_sn", 1, fs(1), 0);
    chk("ch1_clr_wins_done", 1, done_w[1], 0);

    for (int t = 0; t < 30; t++) cyc(4'b1111, 4'b0000);
    chk("mixed_ch2_i", 2, fi(2), 81);
    sel = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < CH; k++) begin
      chk("async_rst_i", k, fi(k), 1);
      chk("async_rst_sn", k, fs(k), 0);
    end
    chk("async_rst_done", 0, done_w, 0);
    chk("async_rst_all_done", 0, all_done_w, 0);
    chk("async_rst_done_cnt", 0, done_cnt_w, 0);
    chk("async_rst_overrun", 0, overrun_w, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 249; t++) cyc(4'b1111, 4'b0000);
    chk("all_before_last", 0, all_done_w, 0);
    cyc(4'b1111, 4'b0000);
    chk("all_done", 0, all_done_w, 1);
    chk("done_cnt_four", 0, done_cnt_w, 4);
    chk("all_i3", 3, fi(3), 251);
    chk("all_sn3", 3, fs(3), 250);
    cyc(4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
